// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: op codes, FSM encoding, iteration count.
package div_unit_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_BUSY    = 2'd1,
    DIV_FIX     = 2'd2,
    DIV_DIVZERO = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sign_conv.sv
// Conditional two's-complement negation of two lanes; used for operand magnitudes
// on entry and for sign restoration of quotient/remainder on exit.
module div_sign_conv #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         neg_a,
  input  logic         neg_b,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb
);

  assign ra = neg_a ? (~a + 1'b1) : a;
  assign rb = neg_b ? (~b + 1'b1) : b;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Optional build macro DIV_EARLY_OUT_EN short-circuits |x| < |y| to a 3-cycle result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         aluControl,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output div_state_t         dbg_state
);

  // Handshake: start is taken only in IDLE with a divide op code and no cancel;
  // busy stays high until the result cycle, where done pulses for exactly one
  // cycle and result is valid; result then holds until the next done or rst.

  div_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH:0]     acc_q, acc_d;     // {partial remainder (WIDTH+1), quotient (WIDTH)}
  logic [WIDTH:0]       dvs_q, dvs_d;
  logic                 sx_q, sx_d, sy_q, sy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
`ifdef DIV_EARLY_OUT_EN
  logic                 early_q, early_d;
`endif

  logic                 is_signed_op, is_div, sx_in, sy_in;
  logic [WIDTH:0]       abs_x, abs_y;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       part;

  assign is_signed_op = (aluControl == EXE_DIV_OP);
  assign is_div       = is_signed_op || (aluControl == EXE_DIVU_OP);
  assign sx_in        = is_signed_op & x[WIDTH-1];
  assign sy_in        = is_signed_op & y[WIDTH-1];

  // Sign-extended to WIDTH+1 so that the magnitude of the most negative value fits.
  div_sign_conv #(.W(WIDTH+1)) u_opnd (
    .a     ({sx_in, x}),
    .b     ({sy_in, y}),
    .neg_a (sx_in),
    .neg_b (sy_in),
    .ra    (abs_x),
    .rb    (abs_y)
  );

  div_sign_conv #(.W(WIDTH)) u_res (
    .a     (acc_q[WIDTH-1:0]),
    .b     (acc_q[2*WIDTH-1:WIDTH]),
    .neg_a (sx_q ^ sy_q),
    .neg_b (sx_q),
    .ra    (quo_s),
    .rb    (rem_s)
  );

  assign shifted = acc_q << 1;
  assign part    = shifted[2*WIDTH:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef DIV_EARLY_OUT_EN
    early_d  = early_q;
`endif
    case (state_q)
      DIV_IDLE: begin
        if (start && is_div && !cancel) begin
          sx_d  = sx_in;
          sy_d  = sy_in;
          dvs_d = abs_y;
          cnt_d = '0;
`ifdef DIV_EARLY_OUT_EN
          early_d = 1'b0;
`endif
          // Divide-by-zero and early-out park |x| in the remainder field so the
          // result lane restores x itself.
          if (y == '0) begin
            acc_d   = {abs_x, {WIDTH{1'b0}}};
            state_d = DIV_DIVZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_x < abs_y) begin
            acc_d   = {abs_x, {WIDTH{1'b0}}};
            early_d = 1'b1;
            state_d = DIV_BUSY;
          end
`endif
          else begin
            acc_d   = {{WIDTH{1'b0}}, abs_x};
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
`ifdef DIV_EARLY_OUT_EN
        if (early_q) begin
          state_d = DIV_FIX;
        end else
`endif
        begin
          if (part >= dvs_q) acc_d = {part - dvs_q, shifted[WIDTH-1:1], 1'b1};
          else               acc_d = shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        result_d = {rem_s, quo_s};
        done_d   = 1'b1;
        state_d  = DIV_IDLE;
      end
      DIV_DIVZERO: begin
        result_d = {rem_s, {WIDTH{1'b1}}};
        done_d   = 1'b1;
        state_d  = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (cancel && state_q != DIV_IDLE) begin
      state_d  = DIV_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef DIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef DIV_EARLY_OUT_EN
      early_q  <= early_d;
`endif
    end
  end

  assign busy      = (state_q != DIV_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
